// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: FSM encoding, parity
// selector codes and the bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Code 2'b11 is treated as "no parity" as well.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two.
// Writes when full and reads when empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter: words enter a FIFO over valid/ready and are
// serialised with per-frame data width, parity and stop-bit configuration.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line high, waiting for a buffered word
// ST_START  | start bit (low) for one bit time
// ST_DATA   | n data bits, LSB first
// ST_PARITY | even/odd parity over the n transmitted bits
// ST_STOP   | one or two stop bits (high); may chain directly into START
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int BIT_RATE   = 9600,
    parameter int CLK_HZ     = 50000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [1:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          uart_txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

    uart_state_t state;
    logic [CW-1:0] bit_cnt;
    logic          bit_end;
    logic          frame_done;
    logic          stop_second;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] head;
    logic       push;
    logic       pop;

    logic [7:0] data_sh;
    logic [2:0] bits_left;
    logic       par_en_q;
    logic       par_bit_q;
    logic       stop2_q;

    logic [7:0] cfg_mask;
    logic       par_en_new;
    logic       par_bit_new;
    logic [2:0] bits_left_new;

    assign tx_ready = !fifo_full && !reset;
    assign push     = tx_valid && tx_ready;

    assign bit_end    = (bit_cnt == CNT_LAST);
    assign frame_done = (state == ST_STOP) && bit_end && (!stop2_q || stop_second);
    assign pop        = !fifo_empty && ((state == ST_IDLE) || frame_done);

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        cfg_mask = 8'hFF;
        unique case (cfg_data_bits)
            2'd0:    cfg_mask = 8'h1F;
            2'd1:    cfg_mask = 8'h3F;
            2'd2:    cfg_mask = 8'h7F;
            default: cfg_mask = 8'hFF;
        endcase
    end

    // Parity is resolved at latch time so the PARITY state only has to drive it.
    assign par_en_new    = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
    assign par_bit_new   = (^(head & cfg_mask)) ^ (cfg_parity == PAR_ODD);
    assign bits_left_new = 3'd4 + {1'b0, cfg_data_bits};

    always_ff @(posedge clk) begin
        if (reset) begin
            data_sh   <= '0;
            bits_left <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else if (pop) begin
            data_sh   <= head;
            bits_left <= bits_left_new;
            par_en_q  <= par_en_new;
            par_bit_q <= par_bit_new;
            stop2_q   <= cfg_stop2;
        end else if (bit_end) begin
            if ((state == ST_START) || ((state == ST_DATA) && (bits_left != 3'd0))) begin
                data_sh <= data_sh >> 1;
            end
            if ((state == ST_DATA) && (bits_left != 3'd0)) begin
                bits_left <= bits_left - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            stop_second <= 1'b0;
            uart_txd    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            if (state != ST_IDLE) begin
                bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    uart_txd <= 1'b1;
                    if (pop) begin
                        state    <= ST_START;
                        uart_txd <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state    <= ST_DATA;
                        uart_txd <= data_sh[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bits_left != 3'd0) begin
                            uart_txd <= data_sh[0];
                        end else if (par_en_q) begin
                            state    <= ST_PARITY;
                            uart_txd <= par_bit_q;
                        end else begin
                            state       <= ST_STOP;
                            uart_txd    <= 1'b1;
                            stop_second <= 1'b0;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state       <= ST_STOP;
                        uart_txd    <= 1'b1;
                        stop_second <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop2_q && !stop_second) begin
                            stop_second <= 1'b1;
                        end else if (pop) begin
                            state    <= ST_START;
                            uart_txd <= 1'b0;
                        end else begin
                            state    <= ST_IDLE;
                            uart_txd <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    uart_txd <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: a queue-based line model checked every cycle,
// directed frames with literal expectations, loop-back decode and random traffic.
module tb_uart_tx_framed;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [1:0] cfg_data_bits = 2'd3;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       uart_txd;
    logic       busy;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_tx_framed #(
        .BIT_RATE   (100000),
        .CLK_HZ     (1000000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .uart_txd      (uart_txd),
        .busy          (busy),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned m_fifo[$];
    bit           m_line[$];
    bit           m_on = 1'b0;
    bit           m_txd = 1'b1;
    bit           m_busy = 1'b0;
    bit           m_can_push;

    // Expand one word into its per-clock line levels (10 clocks per bit).
    function automatic void build_frame(input byte unsigned w, input logic [1:0] db,
                                        input logic [1:0] par, input logic st2);
        int n;
        int ones;
        bit bits[$];
        n = 5 + int'(db);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(w[i]);
            if (w[i]) ones++;
        end
        if (par == 2'b01) bits.push_back((ones % 2) == 1);
        if (par == 2'b10) bits.push_back((ones % 2) == 0);
        bits.push_back(1'b1);
        if (st2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < 10; c++) m_line.push_back(bits[k]);
        end
    endfunction

    always @(posedge clk) begin
        m_can_push = (m_fifo.size() < 4) && !reset;
        if (reset) begin
            m_fifo.delete();
            m_line.delete();
            m_txd  = 1'b1;
            m_busy = 1'b0;
            m_on   = 1'b1;
        end else begin
            if (m_line.size() == 0 && m_fifo.size() > 0)
                build_frame(m_fifo.pop_front(), cfg_data_bits, cfg_parity, cfg_stop2);
            if (tx_valid && m_can_push) m_fifo.push_back(tx_data);
            if (m_line.size() > 0) begin
                m_txd  = m_line.pop_front();
                m_busy = 1'b1;
            end else begin
                m_txd  = 1'b1;
                m_busy = 1'b0;
            end
        end
        #1;
        if (m_on) begin
            check("model_txd", 32'(uart_txd), 32'(m_txd));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_level", 32'(fifo_level), 32'(m_fifo.size()));
            check("model_ready", 32'(tx_ready), 32'((m_fifo.size() < 4) && !reset));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push(input logic [7:0] d, input bit keep);
        int t;
        tx_data  = d;
        tx_valid = 1'b1;
        t = 0;
        while (tx_ready !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("push_timeout", 32'(t), 32'd0);
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic [1:0] par, input logic st2);
        cfg_data_bits = db;
        cfg_parity    = par;
        cfg_stop2     = st2;
    endtask

    // Samples the line at bit centres and measures the frame length up to busy falling.
    task automatic capture(input int nsamp, output logic [15:0] bits, output int len);
        int t;
        bits = '0;
        len  = -1;
        t = 0;
        while (uart_txd !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) return;
        for (int c = 0; c < 2000; c++) begin
            if ((c % 10) == 5 && (c / 10) < nsamp) bits[c/10] = uart_txd;
            if (busy !== 1'b1) begin
                len = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Simple 8N1 receiver sampling bit centres; returns at the stop-bit centre.
    task automatic rx_byte(output logic [7:0] b, output bit ok);
        int t;
        b  = '0;
        ok = 1'b0;
        t = 0;
        while (uart_txd !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) return;
        for (int c = 0; c < 95; c++) begin
            if ((c % 10) == 5 && (c / 10) >= 1 && (c / 10) <= 8) b[c/10-1] = uart_txd;
            @(negedge clk);
        end
        ok = (uart_txd === 1'b1);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        logic [15:0] bits;
        int          len;
        int          t0;
        int          t;
        int          lows;
        logic [7:0]  rb;
        bit          ok;
        logic [7:0]  msg [4];

        repeat (3) @(negedge clk);
        check("reset_txd", 32'(uart_txd), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_ready", 32'(tx_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(tx_ready), 32'd1);
        @(negedge clk);

        // 8N1, 0x41
        set_cfg(2'd3, 2'b00, 1'b0);
        push(8'h41, 1'b0);
        capture(10, bits, len);
        check("8n1_bits", 32'(bits), 32'h282);
        check("8n1_len", 32'(len), 32'd100);

        // 7E2, 0x33
        set_cfg(2'd2, 2'b01, 1'b1);
        push(8'h33, 1'b0);
        capture(11, bits, len);
        check("7e2_bits", 32'(bits), 32'h666);
        check("7e2_len", 32'(len), 32'd110);

        // 7O1, 0x33, with configuration scrambled mid-frame
        set_cfg(2'd2, 2'b10, 1'b0);
        push(8'h33, 1'b0);
        fork
            capture(10, bits, len);
            begin
                repeat (30) @(negedge clk);
                set_cfg(2'd0, 2'b00, 1'b1);
            end
        join
        check("7o1_bits", 32'(bits), 32'h366);
        check("7o1_len", 32'(len), 32'd100);

        // 5N1, 0xFF
        set_cfg(2'd0, 2'b00, 1'b0);
        push(8'hFF, 1'b0);
        capture(7, bits, len);
        check("5n1_bits", 32'(bits), 32'h7E);
        check("5n1_len", 32'(len), 32'd70);

        // Back-to-back behind a warm-up frame
        set_cfg(2'd3, 2'b00, 1'b0);
        push(8'h00, 1'b0);
        t0 = cyc;
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        push(8'h04, 1'b1);
        check("b2b_level_full", 32'(fifo_level), 32'd4);
        check("b2b_ready_low", 32'(tx_ready), 32'd0);
        push(8'h05, 1'b0);
        t = 0;
        while (busy !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("b2b_busy_run", 32'(cyc - t0 - 1), 32'd600);
        check("b2b_level_empty", 32'(fifo_level), 32'd0);

        // Reset during data bit 3 with two words queued
        push(8'hA5, 1'b0);
        t0 = cyc;
        push(8'h11, 1'b1);
        push(8'h22, 1'b0);
        check("rst_queued", 32'(fifo_level), 32'd2);
        while (cyc - t0 < 44) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_ready_low", 32'(tx_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("rst_no_frames", 32'(lows), 32'd0);

        // Loop-back 8N1: "A1B2"
        msg[0] = 8'h41; msg[1] = 8'h31; msg[2] = 8'h42; msg[3] = 8'h32;
        fork
            begin
                push(msg[0], 1'b1);
                push(msg[1], 1'b1);
                push(msg[2], 1'b1);
                push(msg[3], 1'b0);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    rx_byte(rb, ok);
                    check("loop_byte", 32'(rb), 32'(msg[i]));
                    check("loop_stop", 32'(ok), 32'd1);
                end
            end
        join

        // Random traffic, configuration churn and occasional resets
        repeat (4000) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            reset    = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 149) == 0)
                set_cfg(2'($urandom), 2'($urandom), 1'($urandom));
        end
        @(negedge clk);
        tx_valid = 1'b0;
        reset    = 1'b0;
        t = 0;
        while ((busy !== 1'b0 || fifo_level !== 3'd0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", 32'(t < 3000), 32'd1);
        check("drain_txd", 32'(uart_txd), 32'd1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
